// File: rtl/mem_dma_pkg.sv
// Shared encodings for the mem_dma block-transfer engine.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Memory bus initiator performing forward block COPY or constant FILL of up to 255 bytes
// while holding the memory port through the external arbiter.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          MODE,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [7:0]    LEN,
  input  logic [DW-1:0] FILL,
  output logic          BUSY,
  output logic          DONE,
  output logic          BUS_REQ,
  input  logic          BUS_GNT,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WD,
  output logic [AW-1:0] MEM_A,
  input  logic [DW-1:0] MEM_D
);

  state_t        state, state_nxt;
  logic          mode_r;
  logic [AW-1:0] src_r, dst_r;
  logic [7:0]    cnt_r;
  logic [DW-1:0] data_r;

  logic ld_start, ld_read, adv;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Every output is a decode of registered state; only MEM_WE also looks at the live grant.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    BUS_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_A     = '0;
    MEM_WD    = '0;
    ld_start  = 1'b0;
    ld_read   = 1'b0;
    adv       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          ld_start  = 1'b1;
          state_nxt = (LEN == 8'd0) ? ST_FINISH : ST_REQ;
        end
      end
      ST_REQ: begin
        BUSY    = 1'b1;
        BUS_REQ = 1'b1;
        if (BUS_GNT) state_nxt = (mode_r == MODE_COPY) ? ST_READ : ST_WRITE;
      end
      ST_READ: begin
        BUSY    = 1'b1;
        BUS_REQ = 1'b1;
        MEM_A   = src_r;
        if (BUS_GNT) begin
          ld_read   = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        BUSY    = 1'b1;
        BUS_REQ = 1'b1;
        MEM_A   = dst_r;
        MEM_WD  = data_r;
        MEM_WE  = BUS_GNT;
        if (BUS_GNT) begin
          adv = 1'b1;
          if (cnt_r == 8'd1)             state_nxt = ST_FINISH;
          else if (mode_r == MODE_COPY)  state_nxt = ST_READ;
          else                           state_nxt = ST_WRITE;
        end
      end
      ST_FINISH: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FILL is parked in the data register at START so FILL mode never needs a read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_r <= MODE_COPY;
      src_r  <= '0;
      dst_r  <= '0;
      cnt_r  <= '0;
      data_r <= '0;
    end else begin
      if (ld_start) begin
        mode_r <= MODE;
        src_r  <= SRC;
        dst_r  <= DST;
        cnt_r  <= LEN;
        data_r <= FILL;
      end
      if (ld_read) data_r <= MEM_D;
      if (adv) begin
        src_r <= src_r + AW'(1);
        dst_r <= dst_r + AW'(1);
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

endmodule
